encoder_dram_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one full-AXI-master write port among NUM_REQ burst writers
//  (stego-image writer, debug/coefficient dump writers). One burst is in flight at a time.

---
 rtl/encoder_dram_wr_arbiter_pkg.sv | 16 +
 rtl/encoder_dram_wr_arbiter_if.sv | 27 ++
 rtl/encoder_dram_wr_arbiter_rr_priority_pick.sv | 26 ++
 rtl/encoder_dram_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_encoder_dram_wr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_dram_wr_arbiter_pkg.sv
// Shared types and constants for the encoder DRAM write-side arbitration.
// Imported by the arbiter top; the read side can reuse the same burst constants.
package encoder_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbIssue,
    ArbBurst,
    ArbWaitResp
  } arb_state_e;

  localparam int unsigned DEF_IMG_WBURST_LEN = 128;
  localparam int unsigned BEAT_BYTES         = 16;
  localparam int unsigned BYTES_PER_BURST    = DEF_IMG_WBURST_LEN * BEAT_BYTES;

endpackage

// File: rtl/encoder_dram_wr_arbiter_if.sv
// Request/response channel between the write arbiter and the AXI write master.
// master: arbiter side, slave: AXI write master side.
interface encoder_dram_wr_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  axi_m_can_accept_wreq;
  logic                  dram_wreq;
  logic [ADDR_WIDTH-1:0] dram_waddr;
  logic                  wnext;
  logic                  axi_m_wdone;

  modport master (
    input  axi_m_can_accept_wreq,
    input  wnext,
    input  axi_m_wdone,
    output dram_wreq,
    output dram_waddr
  );

  modport slave (
    output axi_m_can_accept_wreq,
    output wnext,
    output axi_m_wdone,
    input  dram_wreq,
    input  dram_waddr
  );
endinterface

// File: rtl/encoder_dram_wr_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set bit of valid starting at ptr, wrapping modulo N.
// Shared by the read- and write-side arbiters.
module rr_priority_pick #(
  parameter int unsigned N   = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int unsigned j;

  always_comb begin
    idx = '0;
    any = |valid;
    j   = 0;
    // Walk from farthest to nearest so the closest valid slot to ptr wins last.
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % int'(N);
      if (valid[j]) idx = IW'(j);
    end
  end

endmodule

// File: rtl/encoder_dram_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master among NUM_REQ burst writers.
// One burst in flight; ownership is held from issue until the write response returns.
module encoder_dram_wr_arbiter
  import encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned IMG_WBURST_LEN = DEF_IMG_WBURST_LEN,
  localparam int unsigned SEL_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          axi_clk,
  input  logic                          axi_reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            req_wnext,
  output logic [NUM_REQ-1:0]            req_burst_done,
  encoder_dram_wr_arbiter_if.master     dram,
  output logic [SEL_W-1:0]              wdata_sel,
  output logic                          beat_err
);

  localparam int unsigned CNT_W = $clog2(IMG_WBURST_LEN);
  // wnext fires LEN-1 times per burst; the last one arrives while the count reads LEN-2.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_WBURST_LEN - 2);

  arb_state_e            state_q, state_d;
  logic [SEL_W-1:0]      owner_q, owner_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] waddr_arr [NUM_REQ];
  logic [SEL_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  wreq;
  logic [NUM_REQ-1:0]    grant, wnext_route, done;

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      waddr_arr[i] = req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  rr_priority_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    waddr_d     = waddr_q;
    err_d       = err_q;
    wreq        = 1'b0;
    grant       = '0;
    wnext_route = '0;
    done        = '0;

    unique case (state_q)
      ArbIdle: begin
        if (pick_any && dram.axi_m_can_accept_wreq) begin
          owner_d = pick_idx;
          waddr_d = waddr_arr[pick_idx];
          state_d = ArbIssue;
        end
      end
      ArbIssue: begin
        wreq           = 1'b1;
        grant[owner_q] = 1'b1;
        rr_ptr_d       = (owner_q == SEL_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        beat_cnt_d     = '0;
        state_d        = ArbBurst;
      end
      ArbBurst: begin
        wnext_route[owner_q] = dram.wnext;
        if (dram.axi_m_wdone) begin
          // Early response: close the burst but flag the short count.
          done[owner_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = ArbIdle;
        end else if (dram.wnext) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_CNT) state_d = ArbWaitResp;
        end
      end
      ArbWaitResp: begin
        if (dram.axi_m_wdone) begin
          done[owner_q] = 1'b1;
          state_d       = ArbIdle;
        end
      end
    endcase

    if (dram.wnext && (state_q != ArbBurst)) err_d = 1'b1;

    // Reset mid-burst must not leak a grant, beat or done pulse.
    if (axi_reset) begin
      wreq        = 1'b0;
      grant       = '0;
      wnext_route = '0;
      done        = '0;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q    <= ArbIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      waddr_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      waddr_q    <= waddr_d;
      err_q      <= err_d;
    end
  end

  assign dram.dram_wreq  = wreq;
  assign dram.dram_waddr = waddr_q;
  assign req_grant       = grant;
  assign req_wnext       = wnext_route;
  assign req_burst_done  = done;
  assign wdata_sel       = owner_q;
  assign beat_err        = err_q;

endmodule

// File: tb/tb_encoder_dram_wr_arbiter.sv
// Self-checking bench for encoder_dram_wr_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_encoder_dram_wr_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned NR  = 2;
  localparam int unsigned LEN = 128;

  logic            axi_clk = 1'b0;
  logic            axi_reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_waddr = '0;
  logic [NR-1:0]   req_grant, req_wnext, req_burst_done;
  logic            wdata_sel;
  logic            beat_err;

  encoder_dram_wr_arbiter_if #(.ADDR_WIDTH(AW)) dram_bus ();

  always #5 axi_clk = ~axi_clk;

  encoder_dram_wr_arbiter #(
    .ADDR_WIDTH     (AW),
    .NUM_REQ        (NR),
    .IMG_WBURST_LEN (LEN)
  ) dut (
    .axi_clk        (axi_clk),
    .axi_reset      (axi_reset),
    .req_valid      (req_valid),
    .req_waddr      (req_waddr),
    .req_grant      (req_grant),
    .req_wnext      (req_wnext),
    .req_burst_done (req_burst_done),
    .dram           (dram_bus.master),
    .wdata_sel      (wdata_sel),
    .beat_err       (beat_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Transaction-level model ----------------
  // Phases: waiting (no burst), pending (grant decided, issues this cycle),
  // in burst (counting beats), awaiting response.
  bit          m_live = 0;
  bit          m_pend, m_burst, m_wait, m_err;
  int          m_owner, m_ptr, m_beats, m_sel;
  logic [AW-1:0] m_addr;
  bit          found;

  always @(posedge axi_clk) begin
    if (axi_reset) begin
      m_live = 1; m_pend = 0; m_burst = 0; m_wait = 0; m_err = 0;
      m_owner = 0; m_ptr = 0; m_beats = 0; m_sel = 0; m_addr = '0;
    end else if (m_live) begin
      if (dram_bus.wnext && !m_burst) m_err = 1;
      if (m_pend) begin
        m_pend = 0; m_burst = 1; m_beats = 0; m_ptr = (m_owner + 1) % NR;
      end else if (m_burst) begin
        if (dram_bus.axi_m_wdone) begin
          m_burst = 0; m_err = 1;
        end else if (dram_bus.wnext) begin
          m_beats++;
          if (m_beats == LEN - 1) begin m_burst = 0; m_wait = 1; end
        end
      end else if (m_wait) begin
        if (dram_bus.axi_m_wdone) m_wait = 0;
      end else if (dram_bus.axi_m_can_accept_wreq) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          if (!found && req_valid[(m_ptr + k) % NR]) begin
            found = 1; m_owner = (m_ptr + k) % NR;
          end
        end
        if (found) begin
          m_pend = 1; m_sel = m_owner; m_addr = req_waddr[m_owner*AW +: AW];
        end
      end
    end
  end

  logic [NR-1:0] e_hot, e_grant, e_wnext, e_done;
  logic          e_wreq;
  int            done_cnt [NR];
  int            wnext_cnt [NR];
  logic [NR-1:0] grant_log [$];

  initial begin
    for (int i = 0; i < NR; i++) begin done_cnt[i] = 0; wnext_cnt[i] = 0; end
  end

  always @(negedge axi_clk) begin
    if (m_live) begin
      e_hot   = NR'(1) << m_owner;
      e_wreq  = !axi_reset && m_pend;
      e_grant = e_wreq ? e_hot : '0;
      e_wnext = (!axi_reset && m_burst && dram_bus.wnext) ? e_hot : '0;
      e_done  = (!axi_reset && (m_burst || m_wait) && dram_bus.axi_m_wdone) ? e_hot : '0;
      chk("cyc_wreq", 64'(dram_bus.dram_wreq), 64'(e_wreq));
      chk("cyc_grant", 64'(req_grant), 64'(e_grant));
      chk("cyc_wnext", 64'(req_wnext), 64'(e_wnext));
      chk("cyc_done", 64'(req_burst_done), 64'(e_done));
      chk("cyc_waddr", 64'(dram_bus.dram_waddr), 64'(m_addr));
      chk("cyc_sel", 64'(wdata_sel), 64'(m_sel));
      chk("cyc_err", 64'(beat_err), 64'(m_err));
    end
    for (int i = 0; i < NR; i++) begin
      if (req_burst_done[i] === 1'b1) done_cnt[i]++;
      if (req_wnext[i] === 1'b1) wnext_cnt[i]++;
    end
    if (req_grant != '0) grant_log.push_back(req_grant);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    req_valid = '0;
    dram_bus.wnext = 1'b0;
    dram_bus.axi_m_wdone = 1'b0;
    tick();
    tick();
    axi_reset = 1'b0;
  endtask

  task automatic wait_wreq(input string name);
    int n = 0;
    while (dram_bus.dram_wreq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(dram_bus.dram_wreq), 64'd1);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      dram_bus.wnext = 1'b1;
      tick();
    end
    dram_bus.wnext = 1'b0;
  endtask

  task automatic finish_resp(input string name, input logic [NR-1:0] exp_done);
    dram_bus.axi_m_wdone = 1'b1;
    #1;
    chk(name, 64'(req_burst_done), 64'(exp_done));
    tick();
    dram_bus.axi_m_wdone = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int w0, w1, d0, nwreq;

  initial begin
    dram_bus.axi_m_can_accept_wreq = 1'b1;
    dram_bus.wnext = 1'b0;
    dram_bus.axi_m_wdone = 1'b0;
    req_waddr = {32'h2000_0000, 32'h1000_0000};
    #1;

    // 1: single requester
    do_reset();
    chk("rst_wreq", 64'(dram_bus.dram_wreq), 64'd0);
    chk("rst_grant", 64'(req_grant), 64'd0);
    chk("rst_sel", 64'(wdata_sel), 64'd0);
    chk("rst_err", 64'(beat_err), 64'd0);
    chk("rst_waddr", 64'(dram_bus.dram_waddr), 64'd0);
    req_valid = 2'b01;
    tick();
    chk("t1_wreq", 64'(dram_bus.dram_wreq), 64'd1);
    chk("t1_grant", 64'(req_grant), 64'h1);
    chk("t1_waddr", 64'(dram_bus.dram_waddr), 64'h1000_0000);
    req_valid = '0;
    tick();
    beats(LEN - 1);
    chk("t1_no_early_done", 64'(done_cnt[0]), 64'd0);
    finish_resp("t1_done", 2'b01);
    chk("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
    chk("t1_err", 64'(beat_err), 64'd0);

    // 2: both requesters continuously valid for four bursts
    do_reset();
    grant_log.delete();
    req_valid = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_wreq("t2_wreq");
      chk("t2_grant", 64'(req_grant), (b % 2 == 0) ? 64'h1 : 64'h2);
      tick();
      chk("t2_sel", 64'(wdata_sel), 64'(b % 2));
      beats(LEN - 1);
      finish_resp("t2_done", (b % 2 == 0) ? 2'b01 : 2'b10);
      if (b == 3) req_valid = '0;
    end
    chk("t2_log_len", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      chk("t2_order0", 64'(grant_log[0]), 64'h1);
      chk("t2_order1", 64'(grant_log[1]), 64'h2);
      chk("t2_order2", 64'(grant_log[2]), 64'h1);
      chk("t2_order3", 64'(grant_log[3]), 64'h2);
    end
    chk("t2_model_ptr", 64'(m_ptr), 64'd0);

    // 3/4: master busy, then owner-1 burst with no leakage to requester 0
    do_reset();
    dram_bus.axi_m_can_accept_wreq = 1'b0;
    req_valid = 2'b10;
    nwreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dram_bus.dram_wreq === 1'b1) nwreq++;
    end
    chk("t3_no_grant", 64'(nwreq), 64'd0);
    dram_bus.axi_m_can_accept_wreq = 1'b1;
    tick();
    chk("t3_wreq", 64'(dram_bus.dram_wreq), 64'd1);
    chk("t3_grant", 64'(req_grant), 64'h2);
    chk("t3_waddr", 64'(dram_bus.dram_waddr), 64'h2000_0000);
    req_valid = '0;
    tick();
    w0 = wnext_cnt[0];
    w1 = wnext_cnt[1];
    beats(LEN - 1);
    chk("t4_wnext0", 64'(wnext_cnt[0] - w0), 64'd0);
    chk("t4_wnext1", 64'(wnext_cnt[1] - w1), 64'd127);
    finish_resp("t3_done", 2'b10);

    // 5: early response and stray beat errors
    do_reset();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    beats(50);
    finish_resp("t5_early_done", 2'b01);
    chk("t5_err", 64'(beat_err), 64'd1);
    tick(); tick(); tick();
    chk("t5_err_sticky", 64'(beat_err), 64'd1);
    do_reset();
    chk("t5_err_cleared", 64'(beat_err), 64'd0);
    dram_bus.wnext = 1'b1;
    tick();
    dram_bus.wnext = 1'b0;
    chk("t5_idle_wnext_err", 64'(beat_err), 64'd1);

    // 6: reset mid-burst, then a fresh request from rr_ptr=0
    do_reset();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    beats(60);
    d0 = done_cnt[1];
    axi_reset = 1'b1;
    dram_bus.wnext = 1'b1;
    dram_bus.axi_m_wdone = 1'b1;
    #1;
    chk("t6_rst_wnext", 64'(req_wnext), 64'd0);
    chk("t6_rst_done", 64'(req_burst_done), 64'd0);
    tick();
    chk("t6_rst_sel", 64'(wdata_sel), 64'd0);
    chk("t6_rst_waddr", 64'(dram_bus.dram_waddr), 64'd0);
    axi_reset = 1'b0;
    dram_bus.wnext = 1'b0;
    dram_bus.axi_m_wdone = 1'b0;
    chk("t6_no_done", 64'(done_cnt[1] - d0), 64'd0);
    req_valid = 2'b11;
    tick();
    chk("t6_grant_rr0", 64'(req_grant), 64'h1);
    req_valid = '0;
    tick();
    beats(LEN - 1);
    finish_resp("t6_done", 2'b01);
    chk("t6_err", 64'(beat_err), 64'd0);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
